// File: rtl/psg_bus_regs_if.sv
// Host-side BDIR/BC1 bus for the PSG register file.
// The host drives the mode and data; the chip returns registered read data.
interface psg_bus_regs_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output bdir, bc1, data_in, input data_out, data_oe);
  modport slave  (input bdir, bc1, data_in, output data_out, data_oe);
endinterface

// File: rtl/psg_bus_regs.sv
// AY-3-8913 style register file: BDIR/BC1 decode, 16 masked registers,
// and static control outputs for the tone/noise/mixer/amp/envelope blocks.
module psg_bus_regs #(
  parameter logic [3:0] CHIP_SEL = 4'h0
) (
  input  logic         clk,
  input  logic         reset,
  psg_bus_regs_if.slave bus,
  output logic [11:0]  tone_period_a,
  output logic [11:0]  tone_period_b,
  output logic [11:0]  tone_period_c,
  output logic [4:0]   noise_period,
  output logic [7:0]   mixer,
  output logic [4:0]   amp_a,
  output logic [4:0]   amp_b,
  output logic [4:0]   amp_c,
  output logic [15:0]  env_period,
  output logic         env_continue,
  output logic         env_attack,
  output logic         env_alternate,
  output logic         env_hold,
  output logic         env_restart,
  output logic [7:0]   io_a,
  output logic [7:0]   io_b
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_LATCH = 2'b11
  } state_e;

  state_e            mode_q, mode_d, state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [3:0]        addr_q, addr_d;
  logic              selected_q, selected_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [15:0][7:0]  regs_q, regs_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              env_restart_q, env_restart_d;
  logic              commit;

  // Unused bits of narrow registers are stored as zero so reads echo the mask.
  function automatic logic [7:0] wmask(input logic [3:0] a, input logic [7:0] v);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: wmask = {4'h0, v[3:0]};
      4'd6, 4'd8, 4'd9, 4'd10: wmask = {3'h0, v[4:0]};
      default:                 wmask = v;
    endcase
  endfunction

  always_comb begin
    mode_d        = state_e'({bus.bdir, bus.bc1});
    data_d        = bus.data_in;
    state_d       = mode_q;
    selected_d    = selected_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    regs_d        = regs_q;
    data_out_d    = 8'h00;
    data_oe_d     = 1'b0;

    // Commit on the edge that closes a WRITE; uses the pre-edge address even
    // when the bus goes straight into LATCH.
    commit        = (state_q == ST_WRITE) && (mode_q != ST_WRITE) && selected_q;
    env_restart_d = commit && (addr_q == 4'd13);
    if (commit) regs_d[addr_q] = wmask(addr_q, wdata_q);

    case (mode_q)
      ST_LATCH: begin
        selected_d = (data_q[7:4] == CHIP_SEL);
        if (data_q[7:4] == CHIP_SEL) addr_d = data_q[3:0];
      end
      ST_WRITE: wdata_d = data_q;
      ST_READ: begin
        data_oe_d = selected_q;
        if (selected_q) data_out_d = regs_q[addr_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= ST_IDLE;
      state_q       <= ST_IDLE;
      data_q        <= 8'h00;
      addr_q        <= 4'h0;
      selected_q    <= 1'b1;
      wdata_q       <= 8'h00;
      regs_q        <= '0;
      data_out_q    <= 8'h00;
      data_oe_q     <= 1'b0;
      env_restart_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      state_q       <= state_d;
      data_q        <= data_d;
      addr_q        <= addr_d;
      selected_q    <= selected_d;
      wdata_q       <= wdata_d;
      regs_q        <= regs_d;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
      env_restart_q <= env_restart_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;

  assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
  assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
  assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
  assign noise_period  = regs_q[6][4:0];
  assign mixer         = regs_q[7];
  assign amp_a         = regs_q[8][4:0];
  assign amp_b         = regs_q[9][4:0];
  assign amp_c         = regs_q[10][4:0];
  assign env_period    = {regs_q[12], regs_q[11]};
  assign env_continue  = regs_q[13][3];
  assign env_attack    = regs_q[13][2];
  assign env_alternate = regs_q[13][1];
  assign env_hold      = regs_q[13][0];
  assign env_restart   = env_restart_q;
  assign io_a          = regs_q[14];
  assign io_b          = regs_q[15];

endmodule

// File: tb/tb_psg_bus_regs.sv
// Directed bench for psg_bus_regs: bus sequences with hand-computed expectations.
module tb_psg_bus_regs;
  localparam logic [1:0] M_IDLE = 2'b00, M_READ = 2'b01, M_WRITE = 2'b10, M_LATCH = 2'b11;

  logic        clk, reset;
  logic [11:0] tone_period_a, tone_period_b, tone_period_c;
  logic [4:0]  noise_period, amp_a, amp_b, amp_c;
  logic [7:0]  mixer, io_a, io_b;
  logic [15:0] env_period;
  logic        env_continue, env_attack, env_alternate, env_hold, env_restart;
  int          total, bad;

  psg_bus_regs_if bus ();

  psg_bus_regs #(.CHIP_SEL(4'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .tone_period_a(tone_period_a), .tone_period_b(tone_period_b), .tone_period_c(tone_period_c),
    .noise_period(noise_period), .mixer(mixer),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .env_period(env_period),
    .env_continue(env_continue), .env_attack(env_attack),
    .env_alternate(env_alternate), .env_hold(env_hold), .env_restart(env_restart),
    .io_a(io_a), .io_b(io_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle, then sample #1 after the edge.
  task automatic step(input logic [1:0] m, input logic [7:0] d);
    {bus.bdir, bus.bc1} = m;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] latch, input logic [7:0] v, input logic exp_rst);
    step(M_LATCH, latch);
    step(M_WRITE, v);
    step(M_IDLE, 8'h00);
    chk("restart_before_commit", env_restart, 0);
    step(M_IDLE, 8'h00);
    chk("restart_at_commit", env_restart, exp_rst);
    step(M_IDLE, 8'h00);
    chk("restart_drop", env_restart, 0);
  endtask

  task automatic read_reg(input logic [7:0] latch, input logic [7:0] exp_d, input logic exp_oe);
    step(M_LATCH, latch);
    step(M_READ, 8'h00);
    step(M_READ, 8'h00);
    chk("read_data", bus.data_out, exp_d);
    chk("read_oe", bus.data_oe, exp_oe);
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    chk("read_oe_drop", bus.data_oe, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    bus.bdir = 1'b0; bus.bc1 = 1'b0; bus.data_in = 8'h00;
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    reset = 1'b0;
    step(M_IDLE, 8'h00);
    chk("rst_tone_a", tone_period_a, 0);
    chk("rst_mixer", mixer, 0);
    chk("rst_oe", bus.data_oe, 0);
    chk("rst_dout", bus.data_out, 0);

    // Program a few registers, then reset mid-stream
    write_reg(8'h07, 8'h3F, 0);
    chk("mixer_w", mixer, 8'h3F);
    write_reg(8'h00, 8'h55, 0);
    chk("tone_a_lo", tone_period_a, 12'h055);
    step(M_LATCH, 8'h07);
    step(M_WRITE, 8'hAA);
    reset = 1'b1;
    #1;
    chk("midrst_mixer", mixer, 0);
    chk("midrst_tone_a", tone_period_a, 0);
    chk("midrst_restart", env_restart, 0);
    chk("midrst_oe", bus.data_oe, 0);
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    reset = 1'b0;
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    chk("post_rst_mixer", mixer, 0);
    read_reg(8'h07, 8'h00, 1);

    // R1 masking
    write_reg(8'h01, 8'hFF, 0);
    chk("tone_a_hi", tone_period_a, 12'hF00);
    read_reg(8'h01, 8'h0F, 1);

    // 5-bit masks and I/O ports
    write_reg(8'h06, 8'hFF, 0);
    chk("noise_mask", noise_period, 5'h1F);
    write_reg(8'h0A, 8'hEA, 0);
    chk("amp_c_mask", amp_c, 5'h0A);
    write_reg(8'h0E, 8'hA5, 0);
    chk("io_a", io_a, 8'hA5);
    write_reg(8'h0F, 8'h5A, 0);
    chk("io_b", io_b, 8'h5A);
    read_reg(8'h0A, 8'h0A, 1);

    // Envelope programming; second R13 write of the same value still restarts
    write_reg(8'h0B, 8'h34, 0);
    write_reg(8'h0C, 8'h12, 0);
    chk("env_period", env_period, 16'h1234);
    write_reg(8'h0D, 8'hFE, 1);
    chk("env_shape", {env_continue, env_attack, env_alternate, env_hold}, 4'b1110);
    read_reg(8'h0D, 8'h0E, 1);
    write_reg(8'h0D, 8'h0E, 1);
    chk("env_shape2", {env_continue, env_attack, env_alternate, env_hold}, 4'b1110);

    // Unselected chip: write discarded (addr still 13), no restart, no drive
    step(M_LATCH, 8'h0D);
    step(M_IDLE, 8'h00);
    write_reg(8'h18, 8'hA1, 0);
    chk("unsel_shape", {env_continue, env_attack, env_alternate, env_hold}, 4'b1110);
    chk("unsel_io_a", io_a, 8'hA5);
    read_reg(8'h18, 8'h00, 0);
    read_reg(8'h08, 8'h00, 1);

    // WRITE directly into LATCH: commit lands on R8, then R9 gets the next write
    step(M_LATCH, 8'h08);
    step(M_WRITE, 8'h1F);
    step(M_LATCH, 8'h09);
    step(M_WRITE, 8'h10);
    chk("direct_amp_a", amp_a, 5'h1F);
    chk("direct_amp_b_old", amp_b, 5'h00);
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    chk("direct_amp_b", amp_b, 5'h10);
    chk("direct_amp_a_kept", amp_a, 5'h1F);

    // Reset during a WRITE to R13
    step(M_LATCH, 8'h0D);
    step(M_WRITE, 8'h05);
    step(M_WRITE, 8'h05);
    reset = 1'b1;
    #1;
    chk("rstw_restart", env_restart, 0);
    step(M_IDLE, 8'h00);
    step(M_IDLE, 8'h00);
    reset = 1'b0;
    step(M_IDLE, 8'h00);
    chk("rstw_restart_post1", env_restart, 0);
    step(M_IDLE, 8'h00);
    chk("rstw_restart_post2", env_restart, 0);
    chk("rstw_shape", {env_continue, env_attack, env_alternate, env_hold}, 4'b0000);
    chk("rstw_amp_a", amp_a, 5'h00);
    read_reg(8'h0D, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
